ccff_chain_loader: RTL and testbench

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_pkg.sv | 21 ++
 rtl/ccff_word_serializer.sv | 38 +++
 rtl/ccff_chain_loader.sv | 112 +++++++++++
 tb/tb_ccff_chain_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// Shared definitions for the configuration-chain loader: state encoding,
// default geometry and a small width helper.
package ccff_pkg;

    localparam int unsigned CCFF_CHAIN_LEN_DEF = 16;
    localparam int unsigned CCFF_WORD_W_DEF    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_WORD,
        ST_SHIFT,
        ST_DONE
    } ccff_state_e;

    // Index width that stays at least one bit for single-bit words.
    function automatic int unsigned ccff_idx_w(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Holds one bitstream word and presents it MSB first, one bit per shift,
// tracking which bit of the word is currently at the head.
module ccff_word_serializer
    import ccff_pkg::*;
#(
    parameter int unsigned WORD_W = CCFF_WORD_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [WORD_W-1:0] i_word,
    output logic              o_msb,
    output logic              o_last
);

    localparam int unsigned IDX_W = ccff_idx_w(WORD_W);

    logic [WORD_W-1:0] r_sreg;
    logic [IDX_W-1:0]  r_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sreg <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_sreg <= i_word;
            r_idx  <= '0;
        end else if (i_shift) begin
            r_sreg <= r_sreg << 1;
            r_idx  <= r_idx + 1'b1;
        end
    end

    assign o_msb  = r_sreg[WORD_W-1];
    assign o_last = (r_idx == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams bitstream words into a serial configuration flip-flop chain:
// clear pulse, then CHAIN_LEN shift cycles fed word by word.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = CCFF_CHAIN_LEN_DEF,
    parameter int unsigned WORD_W    = CCFF_WORD_W_DEF,
    localparam int unsigned BC_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              chain_rst,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              tail_parity,
    output logic [BC_W-1:0]   bit_cnt
);

    ccff_state_e     r_state;
    ccff_state_e     w_next;
    logic [BC_W-1:0] r_bit_cnt;
    logic            r_parity;
    logic            r_aborted;

    logic w_run;
    logic w_start_ok;
    logic w_shift;
    logic w_load;
    logic w_last_chain;
    logic w_msb;
    logic w_last_word;

    // Abort and reset gate the strobes so the chain never sees an edge
    // that the loader's counters do not account for.
    assign w_run        = ~pReset & ~abort;
    assign w_start_ok   = start & ~abort & ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_shift      = w_run & (r_state == ST_SHIFT);
    assign w_load       = w_run & (r_state == ST_WAIT_WORD) & bs_valid;
    assign w_last_chain = (r_bit_cnt == BC_W'(CHAIN_LEN - 1));

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: if (start) w_next = ST_CLEAR;
                ST_CLEAR:         w_next = ST_WAIT_WORD;
                ST_WAIT_WORD:     if (bs_valid) w_next = ST_SHIFT;
                ST_SHIFT: begin
                    if (w_last_chain)     w_next = ST_DONE;
                    else if (w_last_word) w_next = ST_WAIT_WORD;
                end
                default:          w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state <= w_next;
            if (abort) begin
                r_aborted <= 1'b1;
            end else if (w_start_ok) begin
                r_bit_cnt <= '0;
                r_parity  <= 1'b0;
                r_aborted <= 1'b0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_parity  <= r_parity ^ ccff_tail;
            end
        end
    end

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .i_clk   (prog_clk),
        .i_rst   (pReset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_word  (bs_data),
        .o_msb   (w_msb),
        .o_last  (w_last_word)
    );

    assign bs_ready      = w_run & (r_state == ST_WAIT_WORD);
    assign ccff_head     = w_shift & w_msb;
    assign ccff_shift_en = w_shift;
    assign chain_rst     = ~pReset & (r_state == ST_CLEAR);
    assign busy          = ~pReset & ((r_state == ST_CLEAR) || (r_state == ST_WAIT_WORD) ||
                                      (r_state == ST_SHIFT));
    assign done          = ~pReset & (r_state == ST_DONE);
    assign aborted       = r_aborted;
    assign tail_parity   = r_parity;
    assign bit_cnt       = r_bit_cnt;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized and directed bench for ccff_chain_loader with a 16-bit and a
// 4-bit chain, checked against a bit-stream reference model.
module tb_ccff_chain_loader;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       pReset, start, abort, bs_valid, ccff_tail, sel;
    logic [7:0] bs_data;

    logic       a_ready, a_head, a_sen, a_crst, a_busy, a_done, a_abrt, a_par;
    logic [4:0] a_cnt;
    logic       b_ready, b_head, b_sen, b_crst, b_busy, b_done, b_abrt, b_par;
    logic [2:0] b_cnt;

    logic       w_ready, w_head, w_sen, w_crst, w_busy, w_done, w_abrt, w_par;
    logic [4:0] w_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] q_words[$];
    int         q_gaps[$];

    ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_dut16 (
        .prog_clk(clk), .pReset(pReset), .start(start & ~sel), .abort(abort & ~sel),
        .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(a_ready), .ccff_head(a_head),
        .ccff_shift_en(a_sen), .ccff_tail(ccff_tail), .chain_rst(a_crst), .busy(a_busy),
        .done(a_done), .aborted(a_abrt), .tail_parity(a_par), .bit_cnt(a_cnt)
    );

    ccff_chain_loader #(.CHAIN_LEN(4), .WORD_W(8)) u_dut4 (
        .prog_clk(clk), .pReset(pReset), .start(start & sel), .abort(abort & sel),
        .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(b_ready), .ccff_head(b_head),
        .ccff_shift_en(b_sen), .ccff_tail(ccff_tail), .chain_rst(b_crst), .busy(b_busy),
        .done(b_done), .aborted(b_abrt), .tail_parity(b_par), .bit_cnt(b_cnt)
    );

    always_comb begin
        if (sel) begin
            {w_ready, w_head, w_sen, w_crst} = {b_ready, b_head, b_sen, b_crst};
            {w_busy, w_done, w_abrt, w_par}  = {b_busy, b_done, b_abrt, b_par};
            w_cnt = {2'b00, b_cnt};
        end else begin
            {w_ready, w_head, w_sen, w_crst} = {a_ready, a_head, a_sen, a_crst};
            {w_busy, w_done, w_abrt, w_par}  = {a_busy, a_done, a_abrt, a_par};
            w_cnt = a_cnt;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    // cut_kind: 0 = complete load, 1 = abort+start on shift cut_at, 2 = pReset on shift cut_at
    task automatic run_load(input logic sel_i, input int cut_kind, input int cut_at,
                            input logic [31:0] tmask, input bit noise,
                            output logic [31:0] obs_o);
        int cl, exp_sh, shifts, acc, idle_rdy, exp_idle, rst_pulses, overlap, gap_left, wi, nw, bad;
        bit cut, finished;
        logic [31:0] obs, exp_bits;
        logic [7:0] wd;
        logic exp_par;

        cl = sel_i ? 4 : 16;
        nw = (cl + 7) / 8;
        shifts = 0; acc = 0; idle_rdy = 0; rst_pulses = 0; overlap = 0; wi = 0;
        gap_left = q_gaps[0];
        cut = 0; finished = 0; obs = '0;

        @(negedge clk);
        sel = sel_i; start = 1'b1; abort = 1'b0; pReset = 1'b0; bs_valid = 1'b0;

        for (int cyc = 0; cyc < 400 && !finished && !cut; cyc++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; bs_valid = 1'b0;
            ccff_tail = tmask[shifts];
            #1;
            if (cut_kind != 0 && w_sen && shifts == cut_at - 1) begin
                cut = 1;
                if (cut_kind == 1) begin
                    abort = 1'b1; start = 1'b1;
                end else begin
                    pReset = 1'b1;
                end
                #1;
                check_eq("cut_shift_en", 32'(w_sen), 32'd0);
                check_eq("cut_head", 32'(w_head), 32'd0);
            end else begin
                if (w_busy && noise) start = 1'($urandom_range(0, 1));
                if (w_ready) begin
                    if (gap_left > 0) begin
                        gap_left--;
                        idle_rdy++;
                    end else if (wi < q_words.size()) begin
                        bs_valid = 1'b1;
                        bs_data  = q_words[wi];
                    end
                end
                #1;
                if (w_ready && w_sen) overlap++;
                if (w_ready && bs_valid) begin
                    acc++; wi++;
                    gap_left = (wi < q_gaps.size()) ? q_gaps[wi] : 0;
                end
                if (w_sen) begin
                    obs = {obs[30:0], w_head};
                    shifts++;
                end
                if (w_crst) rst_pulses++;
                if (w_done) finished = 1;
            end
        end

        exp_sh = (cut_kind != 0) ? cut_at - 1 : cl;
        exp_bits = '0; exp_par = 1'b0;
        for (int k = 0; k < exp_sh; k++) begin
            wd = q_words[k / 8];
            exp_bits = {exp_bits[30:0], wd[7 - (k % 8)]};
            exp_par ^= tmask[k];
        end
        exp_idle = 0;
        for (int i = 0; i < nw && i < q_gaps.size(); i++) exp_idle += q_gaps[i];

        check_eq("shift_count", 32'(shifts), 32'(exp_sh));
        check_eq("head_bits", obs, exp_bits);
        check_eq("ready_while_shift", 32'(overlap), 32'd0);

        if (cut_kind == 0) begin
            check_eq("load_finished", 32'(finished), 32'd1);
            check_eq("words_accepted", 32'(acc), 32'(nw));
            check_eq("chain_rst_pulses", 32'(rst_pulses), 32'd1);
            check_eq("idle_ready_cycles", 32'(idle_rdy), 32'(exp_idle));
            check_eq("done_bit_cnt", 32'(w_cnt), 32'(cl));
            check_eq("done_parity", 32'(w_par), 32'(exp_par));
            check_eq("done_busy", 32'(w_busy), 32'd0);
            check_eq("done_aborted", 32'(w_abrt), 32'd0);
            bad = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                start = 1'b0; bs_valid = 1'b1; bs_data = 8'hFF;
                #1;
                if (w_ready || w_sen || !w_done) bad++;
            end
            bs_valid = 1'b0;
            check_eq("done_hold", 32'(bad), 32'd0);
        end else begin
            check_eq("cut_reached", 32'(cut), 32'd1);
            @(negedge clk);
            start = 1'b0; abort = 1'b0; pReset = 1'b0; bs_valid = 1'b0;
            #1;
            if (cut_kind == 1) begin
                check_eq("abort_busy", 32'(w_busy), 32'd0);
                check_eq("abort_flag", 32'(w_abrt), 32'd1);
                check_eq("abort_bit_cnt", 32'(w_cnt), 32'(exp_sh));
                check_eq("abort_parity", 32'(w_par), 32'(exp_par));
            end else begin
                check_eq("reset_outputs",
                         32'({w_ready, w_head, w_sen, w_crst, w_busy, w_done, w_abrt, w_par}), 32'd0);
                check_eq("reset_bit_cnt", 32'(w_cnt), 32'd0);
            end
            bad = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                bs_valid = 1'b1; bs_data = 8'hFF;
                #1;
                if (w_sen || w_busy) bad++;
            end
            bs_valid = 1'b0;
            check_eq("post_cut_quiet", 32'(bad), 32'd0);
        end
        obs_o = obs;
    endtask

    initial begin
        logic [31:0] obs;
        logic        s;
        pReset = 1'b1; start = 1'b0; abort = 1'b0; bs_valid = 1'b0;
        bs_data = '0; ccff_tail = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; abort = 1'b1;
        #1;
        check_eq("rst_held_outputs",
                 32'({a_ready, a_head, a_sen, a_crst, a_busy, a_done, b_busy, b_done}), 32'd0);
        @(negedge clk);
        pReset = 1'b0; start = 1'b0; abort = 1'b0;
        #1;
        check_eq("rst_outputs16",
                 32'({a_ready, a_head, a_sen, a_crst, a_busy, a_done, a_abrt, a_par}), 32'd0);
        check_eq("rst_outputs4",
                 32'({b_ready, b_head, b_sen, b_crst, b_busy, b_done, b_abrt, b_par}), 32'd0);
        check_eq("rst_cnt", 32'({a_cnt, b_cnt}), 32'd0);

        q_words = '{8'hA5, 8'h3C}; q_gaps = '{0, 0};
        run_load(1'b0, 0, 0, $urandom, 1'b0, obs);
        check_eq("pattern_a53c", obs, 32'h0000_A53C);

        q_words = '{8'h5E, 8'hC3}; q_gaps = '{0, 0};
        run_load(1'b0, 0, 0, 32'h0000_0884, 1'b0, obs);
        check_eq("parity_three_ones", 32'(w_par), 32'd1);

        q_words = '{8'h96, 8'h1B}; q_gaps = '{0, 5};
        run_load(1'b0, 0, 0, $urandom, 1'b0, obs);
        check_eq("gap_pattern", obs, 32'h0000_961B);

        q_words = '{8'hF0}; q_gaps = '{0};
        run_load(1'b1, 0, 0, $urandom, 1'b0, obs);
        check_eq("short_chain_head", obs, 32'h0000_000F);

        q_words = '{8'($urandom), 8'($urandom)}; q_gaps = '{1, 2};
        run_load(1'b0, 1, 7, $urandom, 1'b0, obs);

        q_words = '{8'($urandom), 8'($urandom)}; q_gaps = '{0, 1};
        run_load(1'b0, 2, int'($urandom_range(2, 16)), $urandom, 1'b0, obs);
        q_words = '{8'hC7, 8'h29}; q_gaps = '{2, 0};
        run_load(1'b0, 0, 0, $urandom, 1'b1, obs);

        for (int t = 0; t < 8; t++) begin
            s = 1'($urandom_range(0, 1));
            q_words = '{8'($urandom), 8'($urandom)};
            q_gaps  = '{int'($urandom_range(0, 3)), int'($urandom_range(0, 3))};
            run_load(s, 0, 0, $urandom, 1'b1, obs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
